cnn_conv_1x1: RTL and testbench
===============================

# cnn_conv_1x1

Multi-channel 1×1 convolution engine for the CNN feature pipeline (encoder and decoder 1×1 projections). It accepts one frame of `CHANNEL_NUM_IN` channel-planar feature maps and a stream of `CHANNEL_NUM_OUT × CHANNEL_NUM_IN` weights. It produces `CHANNEL_NUM_OUT` channel-planar output maps, one pixel per cycle. All arithmetic is signed fixed point.

## Interface
- `DATA_WIDTH`, 32: pixel/weight/result word width.
- `FRAC_BITS`, 16: fractional bits of the signed fixed-point format (Q16.16 by default).
- `IMAGE_WIDTH`, 16: map width in pixels.
- `IMAGE_HEIGHT`, 16: map height in pixels.
- `CHANNEL_NUM_IN`, 4: input channels (CIN).
- `CHANNEL_NUM_OUT`, 4: output channels (COUT).
- `KERNEL`, 1: kernel width; only 1 is supported.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  `pxl_in` carries a valid input pixel this cycle.
- `pxl_in`  in  DATA_WIDTH  input pixel, signed fixed point.
- `valid_weight_in`  in  1  `weight_in` carries a valid weight this cycle.
- `weight_in`  in  DATA_WIDTH  weight, signed fixed point.
- `pxl_out`  out  DATA_WIDTH  output pixel, signed fixed point.
- `valid_out`  out  1  `pxl_out` is valid this cycle.

## Operation
- Definitions: S = IMAGE_WIDTH×IMAGE_HEIGHT. Pixel order is channel-major, then raster (row-major) within a channel: word k = channel k/S, pixel k%S. Weight order is w[co][ci], with word j giving co = j/CIN and ci = j%CIN.
- States: LOAD, COMPUTE, DRAIN.
- LOAD:
  - Every cycle with `valid_in`=1, the pixel is written to bank ci at address p, and the pixel counter advances.
  - Every cycle with `valid_weight_in`=1, the weight is written to register j, and the weight counter advances.
  - The two streams are independent and may overlap, gap, or arrive in either order.
  - Words beyond CIN·S pixels or CIN·COUT weights are ignored.
- LOAD → COMPUTE: when both counts are complete. This includes the cycle in which the final word of either stream is accepted.
- COMPUTE: iterate co = 0..COUT-1 (outer) and p = 0..S-1 (inner), issuing one (co,p) per cycle. Each issue computes y = Σ_ci x[ci][p]·w[co][ci].
  - All CIN banks are read in parallel.
  - CIN multipliers feed a registered adder tree.
- Arithmetic:
  - Full-precision signed products (2·DATA_WIDTH bits).
  - Sum at 2·DATA_WIDTH + clog2(CIN) bits.
  - Arithmetic right shift by FRAC_BITS (truncation toward −∞).
  - Saturate to the signed DATA_WIDTH range: 0x7FFFFFFF / 0x80000000 at default width.
- Output order: COUT·S words, channel-major then raster, contiguous with no gaps.
- DRAIN: lasts until the last result leaves the pipeline. Then both counters clear and the block returns to LOAD. Every frame must resupply both pixels and weights.
- During COMPUTE/DRAIN, `valid_in` and `valid_weight_in` are ignored.
- Reset (asynchronous, `reset`=0) has the following effects:
  - State returns to LOAD; counters clear; pipeline valids clear.
  - `valid_out`=0 and `pxl_out`=0 immediately.
  - Memory contents are not cleared.
  - A reset mid-frame discards the frame.

## Timing
- Pipeline latency L = 3 + clog2(CIN) cycles: bank read, multiply register, one register per adder-tree level, output register. L = 5 at CIN=4.
- The first `valid_out` occurs L cycles after the rising edge that accepts the last required input word.
- `valid_out` then stays high for exactly COUT·S consecutive cycles (1024 at defaults), then drops.
- `pxl_out` holds its last value when `valid_out`=0.
- After the final output, the first input can be accepted on the next cycle.
- The earliest back-to-back frame completes in CIN·S + L + COUT·S cycles.

## Test plan
- Identity weights (w[co][ci] = 0x00010000 if co==ci, else 0) with ramp pixels k → 1024 outputs equal to the input sequence, in order; first `valid_out` 5 cycles after the last pixel is accepted.
- All weights 0x00008000 (0.5), all pixels 0x00020000 (2.0) → every output 0x00040000 (4.0).
- Weights 0xFFFF0000 (−1.0), pixels 0x00018000 (1.5) → every output 0xFFFA0000 (−6.0).
- Pixels 0x7FFFFFFF with weights 0x7FFFFFFF → 0x7FFFFFFF; the same with weights 0x80000000 → 0x80000000 (saturation).
- Stimulus of test 1 with `valid_in` deasserted every other cycle, and weights sent after the pixels → identical output sequence, latency counted from the last weight accepted.
- Assert `reset`=0 at output 100 → `valid_out`=0 immediately, no further outputs; a new full frame then yields the correct 1024 outputs.

Source files
------------

// File: rtl/cnn_conv_1x1.sv
// cnn_conv_1x1: multi-channel 1x1 convolution engine.
// Loads one channel-planar frame plus a COUT x CIN weight set, then streams
// COUT channel-planar output maps, one signed fixed-point pixel per cycle.
module cnn_conv_1x1 #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRAC_BITS       = 16,
    parameter int IMAGE_WIDTH     = 16,
    parameter int IMAGE_HEIGHT    = 16,
    parameter int CHANNEL_NUM_IN  = 4,
    parameter int CHANNEL_NUM_OUT = 4,
    parameter int KERNEL          = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
);

    localparam int DW   = DATA_WIDTH;
    localparam int CIN  = CHANNEL_NUM_IN;
    localparam int COUT = CHANNEL_NUM_OUT;
    localparam int S    = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int LVL  = $clog2(CIN);
    localparam int N2   = 1 << LVL;
    localparam int SUMW = 2 * DW + LVL;
    localparam int NV   = 2 + LVL;
    localparam int PW   = (S > 1) ? $clog2(S) : 1;
    localparam int CIW  = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int COW  = (COUT > 1) ? $clog2(COUT) : 1;

    localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    if (KERNEL != 1) begin : g_bad_kernel
        $error("cnn_conv_1x1 supports KERNEL == 1 only");
    end

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t              state_q;
    logic [CIW-1:0]      wr_ci_q;
    logic [PW-1:0]       wr_p_q;
    logic                pix_done_q;
    logic [COW-1:0]      wr_co_q;
    logic [CIW-1:0]      wr_wci_q;
    logic                wt_done_q;
    logic [COW-1:0]      co_q;
    logic [PW-1:0]       p_q;
    logic [NV-1:0]       vld_q;
    logic                valid_out_q;
    logic [DW-1:0]       pxl_out_q;

    logic signed [DW-1:0]   bank_q [CIN][S];
    logic signed [DW-1:0]   w_q    [COUT][CIN];
    logic signed [DW-1:0]   x_p0_q [CIN];
    logic signed [DW-1:0]   w_p0_q [CIN];
    logic signed [SUMW-1:0] tree_q [LVL+1][N2];

    logic pix_acc, pix_last, pix_done_d;
    logic wt_acc, wt_last, wt_done_d;
    logic issue, issue_last;

    // Shift right by the fractional bits (toward -inf) and clamp to DW bits.
    function automatic logic [DW-1:0] sat(input logic signed [SUMW-1:0] v);
        logic signed [SUMW-1:0] sh;
        sh = v >>> FRAC_BITS;
        if (sh > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
        else if (sh < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        else                   return sh[DW-1:0];
    endfunction

    // Accept strobes for both load streams and the compute issue slot.
    always_comb begin
        pix_acc    = (state_q == LOAD) && valid_in && !pix_done_q;
        pix_last   = pix_acc && (wr_ci_q == CIW'(CIN-1)) && (wr_p_q == PW'(S-1));
        pix_done_d = pix_done_q | pix_last;
        wt_acc     = (state_q == LOAD) && valid_weight_in && !wt_done_q;
        wt_last    = wt_acc && (wr_co_q == COW'(COUT-1)) && (wr_wci_q == CIW'(CIN-1));
        wt_done_d  = wt_done_q | wt_last;
        issue      = (state_q == COMPUTE);
        issue_last = issue && (co_q == COW'(COUT-1)) && (p_q == PW'(S-1));
    end

    // Frame sequencer: load counters, (co,p) issue counters and state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LOAD;
            wr_ci_q    <= '0;
            wr_p_q     <= '0;
            pix_done_q <= 1'b0;
            wr_co_q    <= '0;
            wr_wci_q   <= '0;
            wt_done_q  <= 1'b0;
            co_q       <= '0;
            p_q        <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (pix_acc) begin
                        if (wr_p_q == PW'(S-1)) begin
                            wr_p_q  <= '0;
                            wr_ci_q <= wr_ci_q + 1'b1;
                        end else begin
                            wr_p_q <= wr_p_q + 1'b1;
                        end
                    end
                    if (wt_acc) begin
                        if (wr_wci_q == CIW'(CIN-1)) begin
                            wr_wci_q <= '0;
                            wr_co_q  <= wr_co_q + 1'b1;
                        end else begin
                            wr_wci_q <= wr_wci_q + 1'b1;
                        end
                    end
                    pix_done_q <= pix_done_d;
                    wt_done_q  <= wt_done_d;
                    if (pix_done_d && wt_done_d) begin
                        state_q <= COMPUTE;
                        co_q    <= '0;
                        p_q     <= '0;
                    end
                end
                COMPUTE: begin
                    if (p_q == PW'(S-1)) begin
                        p_q  <= '0;
                        co_q <= co_q + 1'b1;
                    end else begin
                        p_q <= p_q + 1'b1;
                    end
                    if (issue_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    // Leave once only the final result remains, in the output register.
                    if (~|vld_q) begin
                        state_q    <= LOAD;
                        wr_ci_q    <= '0;
                        wr_p_q     <= '0;
                        pix_done_q <= 1'b0;
                        wr_co_q    <= '0;
                        wr_wci_q   <= '0;
                        wt_done_q  <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Pixel banks and weight registers; contents survive reset.
    always_ff @(posedge clk) begin
        if (pix_acc) bank_q[wr_ci_q][wr_p_q] <= pxl_in;
        if (wt_acc)  w_q[wr_co_q][wr_wci_q] <= weight_in;
    end

    // Datapath: parallel bank read, CIN products, registered adder tree.
    always_ff @(posedge clk) begin
        // p0: bank read and weight select
        for (int ci = 0; ci < CIN; ci++) begin
            x_p0_q[ci] <= bank_q[ci][p_q];
            w_p0_q[ci] <= w_q[co_q][ci];
        end
        // p1: full-precision products, zero-padded to a power of two
        for (int i = 0; i < N2; i++) begin
            if (i < CIN) tree_q[0][i] <= SUMW'(x_p0_q[i]) * SUMW'(w_p0_q[i]);
            else         tree_q[0][i] <= '0;
        end
        // p2..: one register per adder-tree level
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < N2 / 2; i++) begin
                if (i < (N2 >> (l + 1)))
                    tree_q[l+1][i] <= tree_q[l][2*i] + tree_q[l][2*i+1];
            end
        end
    end

    // Valid pipeline travelling alongside the datapath stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q       <= '0;
            valid_out_q <= 1'b0;
        end else begin
            vld_q       <= {vld_q[NV-2:0], issue};
            valid_out_q <= vld_q[NV-1];
        end
    end

    // Output register: rounds/saturates the tree result, holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            pxl_out_q <= '0;
        else if (vld_q[NV-1])  pxl_out_q <= sat(tree_q[LVL][0]);
    end

    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_cnn_conv_1x1.sv
// Testbench for cnn_conv_1x1: table-driven constant frames, ramp/identity
// frames, randomized frames against a plain-arithmetic reference, and a
// mid-output reset.
module tb_cnn_conv_1x1;

    localparam int CIN  = 4;
    localparam int COUT = 4;
    localparam int S    = 256;
    localparam int NPIX = CIN * S;
    localparam int NW   = CIN * COUT;
    localparam int NOUT = COUT * S;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] pxl_in = '0;
    logic        valid_weight_in = 1'b0;
    logic [31:0] weight_in = '0;
    logic [31:0] pxl_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] pix [NPIX];
    logic [31:0] wt  [NW];
    time         t_acc;

    typedef struct {
        logic [31:0] pix;
        logic [31:0] wt;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [4];

    cnn_conv_1x1 dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .pxl_in          (pxl_in),
        .valid_weight_in (valid_weight_in),
        .weight_in       (weight_in),
        .pxl_out         (pxl_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: y = sat( (sum_ci x[ci][p]*w[co][ci]) >>> 16 )
    function automatic logic [31:0] ref_out(input int k);
        int co, p;
        logic signed [65:0] acc;
        longint v;
        co = k / S;
        p  = k % S;
        acc = '0;
        for (int ci = 0; ci < CIN; ci++)
            acc = acc + $signed(pix[ci*S + p]) * $signed(wt[co*CIN + ci]);
        acc = acc >>> 16;
        v = longint'(acc);
        if (v > 64'sd2147483647)       v = 64'sd2147483647;
        else if (v < -64'sd2147483648) v = -64'sd2147483648;
        return v[31:0];
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v = {{12{v[19]}}, v[19:0]};
        return v;
    endfunction

    // mode 0: pixels and weights together; 1: pixels every other cycle then
    // weights; 2: independent random gaps on both streams.
    task automatic drive_frame(input int mode);
        int pi, wi, step;
        logic vi, vw;
        pi = 0; wi = 0; step = 0;
        while (pi < NPIX || wi < NW) begin
            case (mode)
                0: begin vi = (pi < NPIX); vw = (wi < NW); end
                1: begin vi = (pi < NPIX) && (step % 2 == 0); vw = (pi >= NPIX) && (wi < NW); end
                default: begin
                    vi = (pi < NPIX) && ($urandom_range(0, 1) == 1);
                    vw = (wi < NW) && ($urandom_range(0, 3) == 0);
                end
            endcase
            valid_in        = vi;
            pxl_in          = vi ? pix[pi] : $urandom;
            valid_weight_in = vw;
            weight_in       = vw ? wt[wi] : $urandom;
            @(posedge clk);
            #1;
            if (vi) pi++;
            if (vw) wi++;
            step++;
        end
        t_acc = $time - 1;
        valid_in = 1'b0;
        valid_weight_in = 1'b0;
    endtask

    // exp_mode 0: reference model, 1: constant cexp, 2: ramp (output n == n).
    task automatic collect(input string name, input int exp_mode, input logic [31:0] cexp,
                           input int abort_at);
        int waitc, n, lat;
        logic [31:0] exp, last;
        waitc = 0;
        last = '0;
        @(negedge clk);
        while (!valid_out && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!valid_out) begin
            checks++;
            errors++;
            $display("FAIL %s first_valid: no valid_out within %0d cycles", name, waitc);
            return;
        end
        lat = int'(($time - 5 - t_acc) / 10);
        check({name, " latency"}, 32'(lat), 32'(LAT));
        n = 0;
        while (valid_out && n < NOUT) begin
            if (n == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check({name, " reset valid_out"}, {31'b0, valid_out}, 32'd0);
                check({name, " reset pxl_out"}, pxl_out, 32'd0);
                return;
            end
            case (exp_mode)
                0:       exp = ref_out(n);
                1:       exp = cexp;
                default: exp = 32'(n);
            endcase
            check($sformatf("%s out[%0d]", name, n), pxl_out, exp);
            last = pxl_out;
            n++;
            @(negedge clk);
        end
        check({name, " output count"}, 32'(n), 32'(NOUT));
        check({name, " valid drop"}, {31'b0, valid_out}, 32'd0);
        check({name, " pxl_out hold"}, pxl_out, last);
    endtask

    task automatic load_identity_ramp();
        for (int k = 0; k < NPIX; k++) pix[k] = 32'(k);
        for (int j = 0; j < NW; j++)   wt[j] = ((j / CIN) == (j % CIN)) ? 32'h0001_0000 : 32'h0;
    endtask

    task automatic load_random();
        for (int k = 0; k < NPIX; k++) pix[k] = rnd_word();
        for (int j = 0; j < NW; j++)   wt[j] = rnd_word();
    endtask

    initial begin
        int seen;
        tbl[0] = '{pix: 32'h0002_0000, wt: 32'h0000_8000, exp: 32'h0004_0000};
        tbl[1] = '{pix: 32'h0001_8000, wt: 32'hFFFF_0000, exp: 32'hFFFA_0000};
        tbl[2] = '{pix: 32'h7FFF_FFFF, wt: 32'h7FFF_FFFF, exp: 32'h7FFF_FFFF};
        tbl[3] = '{pix: 32'h7FFF_FFFF, wt: 32'h8000_0000, exp: 32'h8000_0000};

        repeat (3) @(negedge clk);
        check("reset valid_out", {31'b0, valid_out}, 32'd0);
        check("reset pxl_out", pxl_out, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        load_identity_ramp();
        drive_frame(0);
        collect("identity", 2, '0, -1);

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NPIX; k++) pix[k] = tbl[t].pix;
            for (int j = 0; j < NW; j++)   wt[j] = tbl[t].wt;
            drive_frame(0);
            collect($sformatf("const%0d", t), 1, tbl[t].exp, -1);
        end

        load_identity_ramp();
        drive_frame(1);
        collect("gapped", 2, '0, -1);

        load_random();
        drive_frame(2);
        collect("abort", 0, '0, 100);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("no output after reset", 32'(seen), 32'd0);

        load_random();
        drive_frame(0);
        collect("random0", 0, '0, -1);

        load_random();
        drive_frame(2);
        collect("random2", 0, '0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
